// File: rtl/gcd_stein.sv
// gcd_stein: Stein binary GCD with START/DONE handshake; GCD_CYCLE_COUNT_EN adds a CYCLES latency port.
module gcd_stein #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             done,
  output logic             error,
  output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [7:0]       cycles
`endif
);
  localparam int KW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CHECK, REDUCE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] a_q, b_q, a_d, b_d, y_d;
  logic [KW-1:0] k_q, k_d;
  logic err_d, done_d;
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    a_d = a_q;
    b_d = b_q;
    k_d = k_q;
    y_d = y;
    err_d = error;
    done_d = 1'b0;
    case (state)
      IDLE: if (start) begin
        a_d = a;
        b_d = b;
        k_d = '0;
        state_d = CHECK;
      end
      // With at least one operand zero, a|b is the surviving operand (or 0).
      CHECK: if (a_q == '0 || b_q == '0) begin
        y_d = a_q | b_q;
        err_d = (a_q | b_q) == '0;
        done_d = 1'b1;
        state_d = IDLE;
      end else state_d = REDUCE;
      REDUCE: if (a_q == b_q) begin
        y_d = a_q << k_q;
        err_d = 1'b0;
        done_d = 1'b1;
        state_d = IDLE;
      end else if (!a_q[0] && !b_q[0]) begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        k_d = k_q + 1'b1;
      end else if (!a_q[0]) a_d = a_q >> 1;
      else if (!b_q[0]) b_d = b_q >> 1;
      else if (a_q > b_q) a_d = (a_q - b_q) >> 1;
      else b_d = (b_q - a_q) >> 1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
      y <= '0;
      error <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      k_q <= k_d;
      y <= y_d;
      error <= err_d;
      done <= done_d;
    end
`ifdef GCD_CYCLE_COUNT_EN
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      cycles <= '0;
    end else begin
      if (state == IDLE && start) cnt <= '0;
      else if (busy && cnt != 8'hff) cnt <= cnt + 8'd1;
      if (done_d) cycles <= cnt == 8'hff ? 8'hff : cnt + 8'd1;
    end
`endif
endmodule

// File: doc/gcd_stein.md
# gcd_stein

Parametrised successor to the team's 8-bit GCD engine. It computes the greatest common divisor of two unsigned WIDTH-bit operands using Stein's binary algorithm, which needs only shifts and subtracts and no divider. It adds a BUSY flag, a defined zero-operand policy, and an optional latency counter. It sits behind a START/DONE handshake, driven by a controller or testbench.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range ≥ 2.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset: one clock; asynchronous, active-low.
- START  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A, captured on the accepting edge.
- B  input  WIDTH  operand B, captured on the accepting edge.
- Y  output  WIDTH  result, registered, held until the next result.
- DONE  output  1  one-cycle pulse; Y and ERROR are valid while it is high.
- ERROR  output  1  high when A = B = 0; held together with Y.
- BUSY  output  1  high whenever the FSM is not in IDLE.
- CYCLES  output  8  latency of the last operation. Present only under GCD_CYCLE_COUNT_EN.

## Operation
- **Internal registers**
  - a, b: WIDTH bits each.
  - k: shared power-of-two count, $clog2(WIDTH+1) bits.
- **States:** IDLE, CHECK, REDUCE.
- **IDLE**
  - On START=1: load a←A, b←B, k←0, then go to CHECK.
  - START in any other state is ignored, with no queueing.
- **CHECK (one cycle)**
  - a=0 and b=0: Y←0, ERROR←1.
  - a=0 only: Y←b, ERROR←0.
  - b=0 only: Y←a, ERROR←0.
  - In the three cases above: DONE←1, go to IDLE.
  - Both operands nonzero: go to REDUCE.
- **REDUCE (one action per cycle, first match wins)**
  - a==b: Y←a<<k, ERROR←0, DONE←1, go to IDLE.
  - a and b both even: a←a>>1, b←b>>1, k←k+1.
  - a even: a←a>>1.
  - b even: b←b>>1.
  - Both odd, a>b: a←(a−b)>>1.
  - Both odd, b>a: b←(b−a)>>1.
- **Arithmetic**
  - All values are unsigned.
  - In REDUCE, a and b stay nonzero, and the difference of two odd values cannot underflow.
  - Y = a<<k always fits in WIDTH bits, because the GCD is ≤ min(A,B) when both operands are nonzero.
- **DONE**
  - Registered; high for exactly the one cycle following the finishing edge.
  - Low otherwise.
- **Y and ERROR**
  - Update only on the finishing edge.
  - Otherwise unchanged; they keep their value through the next operation until its own finish.

## Timing
- **Reset values:** Y=0, DONE=0, ERROR=0, BUSY=0, CYCLES=0. State goes to IDLE, and a, b, k are cleared.
- **Reset mid-operation:** aborts immediately, with no DONE pulse.
- **Latency** is counted in edges from the accepting edge (edge 0) to the edge that raises DONE:
  - 1 when either operand is zero.
  - Otherwise at most 2·WIDTH+2.
- **BUSY** is high from the edge after acceptance up to and including the finishing edge.
- **Back-to-back requests:** START high on the finishing edge is ignored. A request is accepted on the next edge, which is also the edge on which DONE falls.
- **Capture:** A and B are only captured at acceptance, so changing them while BUSY has no effect.

## Configuration
- **GCD_CYCLE_COUNT_EN defined**
  - A counter clears on acceptance and increments on every edge while BUSY.
  - CYCLES is loaded on the finishing edge with the latency defined above, saturating at 255.
  - CYCLES holds like Y.
- **GCD_CYCLE_COUNT_EN undefined:** the CYCLES port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset mid-operation: assert RST_N=0 during an A=75, B=60 run → all outputs 0 asynchronously, no DONE pulse; the next START is accepted normally.
- Nonzero operands, WIDTH=8, one START pulse per case:
  - A=21, B=6 → Y=3, ERROR=0, DONE on edge 5, CYCLES=5.
  - A=75, B=60 → Y=15, DONE on edge 6.
  - A=12, B=18 (exercises k) → Y=6, DONE on edge 5.
- Zero operands:
  - A=0, B=0 → Y=0, ERROR=1, DONE on edge 1.
  - A=0, B=6 → Y=6, ERROR=0, DONE on edge 1.
  - A=9, B=0 → Y=9.
- START held high continuously with new A/B while BUSY → operands are ignored until IDLE; Y changes only at DONE pulses.
- WIDTH=16, A=65535, B=65535 → Y=65535 on edge 2. A=65534, B=2 → Y=2. Both finish within 34 edges.
